// File: rtl/uart_boot_loader.sv
// UART-triggered boot-load sequencer: matches an N-byte key on the RX stream, pulses soft
// reset, counts payload bytes, then pulses hard reset once the line has gone idle.
module uart_boot_loader #(
  parameter int          KEY_LEN       = 2,
  parameter logic [63:0] KEY           = 64'h5F70,
  parameter int          SOFT_PULSE    = 1,
  parameter int          IDLE_CYCLES   = 51262976,
  parameter int          FIRST_TIMEOUT = 0,
  parameter int          CNT_W         = 26,
  parameter int          BCNT_W        = 20
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              uart_rx_irq,
  input  logic [7:0]        uart_rx_byte,
  output logic              soft_reset_o,
  output logic              hard_reset_o,
  output logic              busy_o,
  output logic [2:0]        state_o,
  output logic [BCNT_W-1:0] byte_count_o,
  output logic [2:0]        key_idx_o
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PULSE      = 3'd1,
    ST_WAIT_FIRST = 3'd2,
    ST_LOAD       = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  localparam logic [2:0]        KEY_LAST    = 3'(KEY_LEN - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST  = CNT_W'(SOFT_PULSE - 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam bit                HAS_TIMEOUT = (FIRST_TIMEOUT > 0);
  localparam logic [CNT_W-1:0]  FIRST_LAST  = CNT_W'(HAS_TIMEOUT ? FIRST_TIMEOUT - 1 : 0);
  localparam logic [BCNT_W-1:0] BCNT_MAX    = {BCNT_W{1'b1}};

  // Key byte idx, counted from the most significant end of the packed key.
  function automatic logic [7:0] key_byte(input logic [2:0] idx);
    return 8'(KEY >> (8 * (KEY_LEN - 1 - int'(idx))));
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [BCNT_W-1:0]   bcnt_r, bcnt_s;
  logic [2:0]          key_idx_r, key_idx_s;

  // State, counter and key-progress registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bcnt_r    <= '0;
      key_idx_r <= 3'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bcnt_r    <= bcnt_s;
      key_idx_r <= key_idx_s;
    end
  end

  // Next-state logic; cnt_r times the soft pulse, the first-byte wait and the idle gap.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bcnt_s    = bcnt_r;
    key_idx_s = key_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (uart_rx_irq) begin
          if (uart_rx_byte == key_byte(key_idx_r)) begin
            if (key_idx_r == KEY_LAST) begin
              state_s   = ST_PULSE;
              key_idx_s = 3'd0;
              cnt_s     = '0;
              bcnt_s    = '0;
            end else begin
              key_idx_s = key_idx_r + 3'd1;
            end
          end else if (uart_rx_byte == key_byte(3'd0)) begin
            key_idx_s = 3'd1;
          end else begin
            key_idx_s = 3'd0;
          end
        end else begin
          key_idx_s = key_idx_r;
        end
      end
      ST_PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          state_s = ST_WAIT_FIRST;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_WAIT_FIRST: begin
        if (uart_rx_irq) begin
          state_s = ST_LOAD;
          cnt_s   = '0;
          bcnt_s  = BCNT_W'(1);
        end else if (HAS_TIMEOUT) begin
          if (cnt_r == FIRST_LAST) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_LOAD: begin
        if (uart_rx_irq) begin
          cnt_s  = '0;
          bcnt_s = (bcnt_r == BCNT_MAX) ? bcnt_r : bcnt_r + BCNT_W'(1);
        end else if (cnt_r == IDLE_LAST) begin
          state_s = ST_DONE;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_s   = ST_IDLE;
        key_idx_s = 3'd0;
        cnt_s     = '0;
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        key_idx_s = 3'd0;
      end
    endcase
  end

  // Decoded straight from registers so reset releases both pulses asynchronously.
  assign soft_reset_o = (state_r != ST_PULSE);
  assign hard_reset_o = (state_r != ST_DONE);
  assign busy_o       = (state_r != ST_IDLE);
  assign state_o      = state_r;
  assign byte_count_o = bcnt_r;
  assign key_idx_o    = key_idx_r;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench: three loader instances (main, first-byte timeout, 3-bit byte count)
// share one stimulus stream; expectations come from spec-level arithmetic and a key model.
module tb_uart_boot_loader;

  localparam int PULSE_LEN = 3;
  localparam int IDLE_LEN  = 16;
  localparam int FT_LEN    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic soft_m, hard_m, busy_m; logic [2:0] state_m, kidx_m; logic [19:0] bcnt_m;
  logic soft_t, hard_t, busy_t; logic [2:0] state_t, kidx_t; logic [19:0] bcnt_t;
  logic soft_s, hard_s, busy_s; logic [2:0] state_s, kidx_s; logic [2:0]  bcnt_s;

  int checks = 0;
  int errors = 0;
  logic [7:0] key_b [2] = '{8'h5F, 8'h70};

  always #5 clk = ~clk;

  uart_boot_loader #(.KEY_LEN(2), .KEY(64'h5F70), .SOFT_PULSE(PULSE_LEN), .IDLE_CYCLES(IDLE_LEN),
    .FIRST_TIMEOUT(0), .CNT_W(8), .BCNT_W(20)) dut (
    .clk_i(clk), .reset_i(rst), .uart_rx_irq(irq), .uart_rx_byte(rx_byte),
    .soft_reset_o(soft_m), .hard_reset_o(hard_m), .busy_o(busy_m), .state_o(state_m),
    .byte_count_o(bcnt_m), .key_idx_o(kidx_m));

  uart_boot_loader #(.KEY_LEN(2), .KEY(64'h5F70), .SOFT_PULSE(PULSE_LEN), .IDLE_CYCLES(IDLE_LEN),
    .FIRST_TIMEOUT(FT_LEN), .CNT_W(8), .BCNT_W(20)) dut_to (
    .clk_i(clk), .reset_i(rst), .uart_rx_irq(irq), .uart_rx_byte(rx_byte),
    .soft_reset_o(soft_t), .hard_reset_o(hard_t), .busy_o(busy_t), .state_o(state_t),
    .byte_count_o(bcnt_t), .key_idx_o(kidx_t));

  uart_boot_loader #(.KEY_LEN(2), .KEY(64'h5F70), .SOFT_PULSE(PULSE_LEN), .IDLE_CYCLES(IDLE_LEN),
    .FIRST_TIMEOUT(0), .CNT_W(8), .BCNT_W(3)) dut_sat (
    .clk_i(clk), .reset_i(rst), .uart_rx_irq(irq), .uart_rx_byte(rx_byte),
    .soft_reset_o(soft_s), .hard_reset_o(hard_s), .busy_o(busy_s), .state_o(state_s),
    .byte_count_o(bcnt_s), .key_idx_o(kidx_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    irq = 1'b1;
    rx_byte = b;
    tick();
    irq = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_key();
    send(key_b[0]);
    send(key_b[1]);
  endtask

  // Payload strobes with gaps of gmin..gmax idle cycles; notes any main hard-reset low.
  task automatic send_payload(input int n, input int gmin, input int gmax, output bit hard_seen);
    hard_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      send(8'($urandom_range(0, 255)));
      hard_seen |= !hard_m;
      if (i < n - 1) begin
        repeat ($urandom_range(gmin, gmax)) begin
          tick();
          hard_seen |= !hard_m;
        end
      end
    end
  endtask

  // Ticks after the last strobe; reports the first tick where hard reset is low and how many.
  task automatic watch_hard(output int first_low, output int low_count);
    first_low = -1;
    low_count = 0;
    for (int k = 1; k <= IDLE_LEN + 8; k++) begin
      tick();
      if (!hard_m) begin
        low_count++;
        if (first_low < 0) first_low = k;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({soft_m, hard_m, busy_m} !== 3'b110) begin errors++;
      $display("FAIL reset_outs: got %b expected 110", {soft_m, hard_m, busy_m}); end
    checks++; if ({state_m, kidx_m} !== 6'd0 || bcnt_m !== 20'd0) begin errors++;
      $display("FAIL reset_regs: state %0d kidx %0d bcnt %0d expected 0", state_m, kidx_m, bcnt_m); end
    checks++; if (state_t !== 3'd0 || state_s !== 3'd0) begin errors++;
      $display("FAIL reset_others: got %0d/%0d expected 0", state_t, state_s); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int low_cnt, first_low, hlow, hcnt;
    bit first_soft, hard_seen;
    do_reset();
    send(key_b[0]);
    checks++; if (kidx_m !== 3'd1) begin errors++;
      $display("FAIL basic_kidx: got %0d expected 1", kidx_m); end
    send(key_b[1]);
    first_soft = soft_m;
    low_cnt = 0;
    for (int i = 0; i < PULSE_LEN + 3; i++) begin
      if (!soft_m) low_cnt++;
      tick();
    end
    checks++; if (first_soft !== 1'b0) begin errors++;
      $display("FAIL basic_soft_start: got %b expected 0", first_soft); end
    checks++; if (low_cnt != PULSE_LEN) begin errors++;
      $display("FAIL basic_soft_len: got %0d expected %0d", low_cnt, PULSE_LEN); end
    checks++; if (state_m !== 3'd2 || !busy_m) begin errors++;
      $display("FAIL basic_wait_first: state %0d busy %b expected 2/1", state_m, busy_m); end
    send_payload(5, 3, 3, hard_seen);
    checks++; if (bcnt_m !== 20'd5 || hard_seen) begin errors++;
      $display("FAIL basic_count: got %0d hard_seen %b expected 5/0", bcnt_m, hard_seen); end
    watch_hard(first_low, hcnt);
    hlow = first_low;
    checks++; if (hlow != IDLE_LEN || hcnt != 1) begin errors++;
      $display("FAIL basic_hard: first %0d count %0d expected %0d/1", hlow, hcnt, IDLE_LEN); end
    checks++; if (state_m !== 3'd0 || busy_m || bcnt_m !== 20'd5) begin errors++;
      $display("FAIL basic_end: state %0d busy %b bcnt %0d expected 0/0/5", state_m, busy_m, bcnt_m); end
  endtask

  task automatic test_random_loads();
    int n, first_low, hcnt;
    bit hard_seen;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      send_key();
      repeat ($urandom_range(PULSE_LEN, PULSE_LEN + 6)) tick();
      n = $urandom_range(1, 12);
      send_payload(n, 1, IDLE_LEN - 1, hard_seen);
      checks++; if (bcnt_m !== 20'(n) || hard_seen) begin errors++;
        $display("FAIL rand_count[%0d]: got %0d hard_seen %b expected %0d/0", it, bcnt_m, hard_seen, n); end
      watch_hard(first_low, hcnt);
      checks++; if (first_low != IDLE_LEN || hcnt != 1) begin errors++;
        $display("FAIL rand_hard[%0d]: first %0d count %0d expected %0d/1", it, first_low, hcnt, IDLE_LEN); end
    end
  endtask

  task automatic test_key_restart();
    int idx;
    logic [7:0] b;
    do_reset();
    send(8'h5F);
    send(8'h5F);
    checks++; if (kidx_m !== 3'd1) begin errors++;
      $display("FAIL restart_kidx: got %0d expected 1", kidx_m); end
    send(8'h70);
    checks++; if (state_m !== 3'd1 || soft_m !== 1'b0) begin errors++;
      $display("FAIL restart_pulse: state %0d soft %b expected 1/0", state_m, soft_m); end
    do_reset();
    send(8'h5F);
    send(8'h41);
    checks++; if (kidx_m !== 3'd0) begin errors++;
      $display("FAIL broken_kidx: got %0d expected 0", kidx_m); end
    send(8'h70);
    checks++; if (state_m !== 3'd0 || soft_m !== 1'b1) begin errors++;
      $display("FAIL broken_nopulse: state %0d soft %b expected 0/1", state_m, soft_m); end
    // Random byte stream against the key-matching rule.
    do_reset();
    idx = 0;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: b = key_b[0];
        1: b = key_b[1];
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b);
      if (b == key_b[idx] && idx == 1) begin
        checks++; if (state_m !== 3'd1) begin errors++;
          $display("FAIL rand_key_pulse[%0d]: got state %0d expected 1", i, state_m); end
        do_reset();
        idx = 0;
      end else begin
        if (b == key_b[idx]) idx = idx + 1;
        else if (b == key_b[0]) idx = 1;
        else idx = 0;
        checks++; if (kidx_m !== 3'(idx) || state_m !== 3'd0) begin errors++;
          $display("FAIL rand_key_idx[%0d]: got %0d/%0d expected %0d/0", i, kidx_m, state_m, idx); end
      end
    end
  endtask

  task automatic test_threshold_race();
    int first_low, hcnt;
    do_reset();
    send_key();
    repeat (PULSE_LEN) tick();
    send(8'hA5);
    repeat (IDLE_LEN - 1) tick();
    send(8'h3C);
    checks++; if (state_m !== 3'd3 || hard_m !== 1'b1 || bcnt_m !== 20'd2) begin errors++;
      $display("FAIL race_stay: state %0d hard %b bcnt %0d expected 3/1/2", state_m, hard_m, bcnt_m); end
    watch_hard(first_low, hcnt);
    checks++; if (first_low != IDLE_LEN || hcnt != 1) begin errors++;
      $display("FAIL race_hard: first %0d count %0d expected %0d/1", first_low, hcnt, IDLE_LEN); end
  endtask

  task automatic test_first_timeout();
    int back_idle;
    bit hard_seen;
    do_reset();
    send_key();
    checks++; if (state_t !== 3'd1) begin errors++;
      $display("FAIL to_pulse: got %0d expected 1", state_t); end
    back_idle = -1;
    hard_seen = 1'b0;
    for (int k = 1; k <= PULSE_LEN + FT_LEN + 8; k++) begin
      tick();
      hard_seen |= !hard_t;
      if (state_t === 3'd0 && back_idle < 0) back_idle = k;
    end
    checks++; if (back_idle != PULSE_LEN + FT_LEN) begin errors++;
      $display("FAIL to_abort: idle after %0d expected %0d", back_idle, PULSE_LEN + FT_LEN); end
    checks++; if (hard_seen || bcnt_t !== 20'd0) begin errors++;
      $display("FAIL to_quiet: hard_seen %b bcnt %0d expected 0/0", hard_seen, bcnt_t); end
    checks++; if (state_m !== 3'd2) begin errors++;
      $display("FAIL no_timeout_wait: got %0d expected 2", state_m); end
  endtask

  task automatic test_saturation();
    int first_low, hcnt;
    bit hard_seen;
    do_reset();
    send_key();
    repeat (PULSE_LEN) tick();
    send_payload(10, 1, 3, hard_seen);
    checks++; if (bcnt_s !== 3'd7) begin errors++;
      $display("FAIL sat_count: got %0d expected 7", bcnt_s); end
    checks++; if (bcnt_m !== 20'd10) begin errors++;
      $display("FAIL wide_count: got %0d expected 10", bcnt_m); end
    watch_hard(first_low, hcnt);
  endtask

  task automatic test_reset_mid();
    bit hard_seen;
    do_reset();
    send_key();
    tick();
    checks++; if (soft_m !== 1'b0) begin errors++;
      $display("FAIL mid_pre: soft %b expected 0", soft_m); end
    #2 rst = 1'b1;
    #1;
    checks++; if (soft_m !== 1'b1 || state_m !== 3'd0 || kidx_m !== 3'd0 || bcnt_m !== 20'd0) begin errors++;
      $display("FAIL mid_pulse_reset: soft %b state %0d kidx %0d bcnt %0d expected 1/0/0/0",
               soft_m, state_m, kidx_m, bcnt_m); end
    tick();
    rst = 1'b0;
    tick();
    send_key();
    repeat (PULSE_LEN) tick();
    send_payload(3, 1, 2, hard_seen);
    #3 rst = 1'b1;
    #1;
    checks++; if (bcnt_m !== 20'd0 || state_m !== 3'd0 || busy_m !== 1'b0) begin errors++;
      $display("FAIL mid_load_reset: bcnt %0d state %0d busy %b expected 0/0/0", bcnt_m, state_m, busy_m); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n1, n2, first_low, hcnt;
    bit hard_seen;
    do_reset();
    n1 = $urandom_range(2, 6);
    n2 = $urandom_range(1, 6);
    send_key();
    repeat (PULSE_LEN) tick();
    send_payload(n1, 1, 5, hard_seen);
    watch_hard(first_low, hcnt);
    checks++; if (bcnt_m !== 20'(n1)) begin errors++;
      $display("FAIL b2b_hold: got %0d expected %0d", bcnt_m, n1); end
    send_key();
    send(8'hAA);
    checks++; if (bcnt_m !== 20'd0 || state_m !== 3'd1) begin errors++;
      $display("FAIL b2b_clear: bcnt %0d state %0d expected 0/1", bcnt_m, state_m); end
    repeat (PULSE_LEN - 1) tick();
    checks++; if (state_m !== 3'd2) begin errors++;
      $display("FAIL b2b_pulse_len: got %0d expected 2", state_m); end
    send_payload(n2, 1, 5, hard_seen);
    watch_hard(first_low, hcnt);
    checks++; if (bcnt_m !== 20'(n2) || first_low != IDLE_LEN) begin errors++;
      $display("FAIL b2b_second: bcnt %0d first %0d expected %0d/%0d", bcnt_m, first_low, n2, IDLE_LEN); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_random_loads();
    test_key_restart();
    test_threshold_race();
    test_first_timeout();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Parametrised UART-triggered boot-load sequencer, the successor to the fixed two-byte loader.
- Watches the UART RX byte stream for a configurable N-byte key. On a match it pulses soft reset so the core enters its bootloader, then counts payload bytes.
- When the line has been idle for a configurable time it pulses hard reset to start the new image.
- Exposes state and byte-count status for LEDs and debug.

Parameters:
- KEY_LEN, 2: number of key bytes, 1..8.
- KEY, 64'h5F70: key bytes packed LSB-aligned; first expected byte is KEY[8*KEY_LEN-1 -: 8]. Default is '_' then 'p'.
- SOFT_PULSE, 1: soft_reset_o low duration in cycles, at least 1.
- IDLE_CYCLES, 51262976: idle cycles after the last payload byte before hard reset, at least 2.
- FIRST_TIMEOUT, 0: cycles to wait for the first payload byte; 0 means wait forever.
- CNT_W, 26: width of the idle/timeout counter. Must hold max(IDLE_CYCLES, FIRST_TIMEOUT).
- BCNT_W, 20: width of the payload byte counter.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: asynchronous, active-high reset.
- uart_rx_irq, input, 1: one-cycle strobe, a byte has been received.
- uart_rx_byte, input, 8: received byte, valid when uart_rx_irq=1.
- soft_reset_o, output, 1: active-low core soft reset.
- hard_reset_o, output, 1: active-low system hard reset.
- busy_o, output, 1: high in any state other than IDLE.
- state_o, output, 3: state code, for LEDs.
- byte_count_o, output, BCNT_W: payload bytes received in the current/last load, saturating.
- key_idx_o, output, 3: key bytes matched so far.

Behaviour:
- Reset (reset_i=1, asynchronous):
  - state=IDLE, key_idx=0, counters=0, byte_count_o=0.
  - soft_reset_o=1, hard_reset_o=1, busy_o=0.
- State codes: IDLE=0, PULSE=1, WAIT_FIRST=2, LOAD=3, DONE=4.
- Outputs are decoded from registered state and counters. soft_reset_o=0 only in PULSE; hard_reset_o=0 only in DONE.
- All transitions happen on the rising edge of clk_i.
- IDLE (key matching, evaluated on each rx strobe):
  - If byte equals key byte[key_idx] and key_idx=KEY_LEN-1: go to PULSE, key_idx<=0.
  - Else if byte equals key byte[key_idx]: key_idx<=key_idx+1.
  - Else if byte equals key byte[0]: key_idx<=1. This is simple restart; no further overlap search.
  - Else: key_idx<=0.
  - With no strobe, key_idx holds.
  - With KEY_LEN=1, a single matching byte goes directly to PULSE.
- Entering PULSE: byte_count_o<=0 and the counter is cleared.
- PULSE:
  - Lasts exactly SOFT_PULSE cycles, then goes to WAIT_FIRST.
  - RX strobes here are ignored and not counted.
- WAIT_FIRST:
  - On an rx strobe: byte_count_o<=1, counter<=0, go to LOAD.
  - If FIRST_TIMEOUT>0, the counter increments each cycle without a strobe. When it reaches FIRST_TIMEOUT-1 with no strobe, go to IDLE (abort). No hard reset is issued and byte_count_o stays 0.
  - If FIRST_TIMEOUT=0, the state waits forever.
- LOAD:
  - Each rx strobe: counter<=0 and byte_count_o increments, saturating at all-ones.
  - Each cycle without a strobe: counter increments.
  - When counter=IDLE_CYCLES-1 and there is no strobe in that cycle: go to DONE.
  - So DONE is entered exactly IDLE_CYCLES cycles after the last strobe.
  - A strobe in the threshold cycle wins: the counter clears and the state stays LOAD.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE with key_idx=0.
  - byte_count_o holds its final value until the next PULSE entry.
  - A strobe in DONE is ignored.
- Reset asserted mid-operation returns to IDLE immediately and the reset values apply. Any in-progress pulse is deasserted asynchronously.

Test Plan (params: KEY_LEN=2, KEY=16'h5F70, SOFT_PULSE=3, IDLE_CYCLES=16, FIRST_TIMEOUT=0, unless noted):
- Basic load:
  - Stimulus: bytes 0x5F, 0x70, then 5 payload bytes 4 cycles apart.
  - Required: soft_reset_o low for exactly 3 cycles starting the cycle after the 0x70 strobe.
  - Required: byte_count_o=5.
  - Required: hard_reset_o low for one cycle exactly 16 cycles after the last strobe; state_o then returns to 0.
- Key restart:
  - Stimulus: bytes 0x5F, 0x5F, 0x70.
  - Required: PULSE entered. Stimulus: 0x5F, 0x41, 0x70. Required: no pulse, key_idx_o=0 after 0x41.
- Threshold race:
  - Stimulus: payload strobe arriving exactly at counter=15.
  - Required: no DONE; hard reset occurs 16 cycles after that strobe instead.
- First-byte timeout (FIRST_TIMEOUT=10):
  - Stimulus: key only, no payload.
  - Required: state returns to IDLE 10 cycles after PULSE ends; hard_reset_o never goes low; byte_count_o=0.
- Saturation (BCNT_W=3):
  - Stimulus: 10 payload bytes.
  - Required: byte_count_o=7.
- Reset mid-operation:
  - Stimulus: assert reset_i during the 2nd PULSE cycle.
  - Required: soft_reset_o=1 immediately (same cycle, asynchronous), state_o=0, byte_count_o=0, key_idx_o=0.
